clk_div_bank: RTL and testbench
===============================

CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 SHALL have parameter: NUM_CH, 4, number of independent divider channels (1..16).
REQ-002 SHALL have parameter: CNT_W, 26, divisor/counter width in bits.
REQ-003 SHALL have parameter: DEFAULT_DIV, 20_000_000, divisor loaded into every channel at reset.
REQ-004 SHALL have port: clk  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port: en  input  NUM_CH  per-channel run enable.
REQ-007 SHALL have port: div_load  input  1  one-cycle strobe writing div_val into channel div_ch.
REQ-008 SHALL have port: div_ch  input  clog2(NUM_CH) (min 1)  target channel index for div_load.
REQ-009 SHALL have port: div_val  input  CNT_W  new divisor, legal range 1..2^CNT_W-1.
REQ-010 SHALL have port: sync  input  1  one-cycle strobe realigning all channels.
REQ-011 SHALL have port: tick  output  NUM_CH  one-cycle pulse per channel at terminal count.
REQ-012 SHALL have port: div_clk  output  NUM_CH  50% square wave, toggles on each tick.
REQ-013 SHALL have port: load_err  output  1  one-cycle pulse flagging a rejected div_load.

Function
REQ-014 Each channel SHALL hold a counter cnt, an active divisor div_act and a pending divisor div_pend with pend_valid flag.
REQ-015 With en[i]=1, cnt SHALL increment each cycle; at cnt==div_act-1 it SHALL wrap to 0, tick[i] SHALL be 1 for that one cycle (registered, asserted the cycle after wrap), and div_clk[i] SHALL toggle.
REQ-016 Resulting periods SHALL be: tick every div_act cycles; div_clk period 2*div_act cycles.
REQ-017 div_act==1 SHALL give tick held high every cycle and div_clk toggling every cycle.
REQ-018 With en[i]=0, cnt, div_clk[i] SHALL hold value and tick[i] SHALL be 0; re-enabling resumes from held cnt.
REQ-019 div_load with div_val==0 or div_ch>=NUM_CH SHALL be ignored and load_err SHALL pulse 1 cycle later.
REQ-020 Valid div_load to a running channel SHALL store div_pend, set pend_valid; div_act SHALL update only at that channel's next wrap (glitch-free, current period completes).
REQ-021 Valid div_load to a disabled channel SHALL update div_act immediately, clear cnt to 0, leave div_clk unchanged.
REQ-022 A second div_load before the wrap SHALL overwrite div_pend (last write wins).
REQ-023 sync SHALL, on the next edge, clear every cnt to 0, drive every div_clk to 0, force tick to 0, and promote any pending divisor into div_act regardless of en.
REQ-024 div_load and sync in the same cycle: load SHALL be applied first, then sync, so the new divisor is active immediately.
REQ-025 Counter arithmetic SHALL be CNT_W bits, unsigned, compare against div_act-1; no overflow possible since cnt<div_act.

Reset
REQ-026 rst_n=0 sampled on a clk edge SHALL set cnt=0, div_act=div_pend=DEFAULT_DIV, pend_valid=0, tick=0, div_clk=0, load_err=0 for all channels.
REQ-027 Reset SHALL take priority over sync, div_load and en; reset mid-period discards the pending divisor.
REQ-028 First tick after rst_n deasserts with en=1 SHALL occur DEFAULT_DIV cycles later.

Structure
REQ-029 Package clk_div_pkg SHALL hold default NUM_CH, CNT_W, DEFAULT_DIV constants and the channel-index width function.
REQ-030 One sub-module clk_div_ch SHALL implement a single channel (cnt, div_act, div_pend, tick, div_clk); top generates NUM_CH instances plus load decode and load_err.
REQ-031 No derived signal SHALL be used as a clock; div_clk is a data output only.

Verification
REQ-032 DEFAULT_DIV=5, en=1 after reset -> tick every 5 cycles, div_clk period 10 cycles, first tick 5 cycles after reset release.
REQ-033 ch0 running div 5, div_load div_val=3 at cnt=1 -> current 5-cycle period completes, then ticks every 3 cycles.
REQ-034 div_load div_val=0, then div_ch=NUM_CH -> load_err pulses twice, channel periods unchanged.
REQ-035 ch0 div 4, ch1 div 6 free-running, sync pulse -> both div_clk low and both ticks 4 and 6 cycles later respectively, aligned.
REQ-036 en[2] dropped for 7 cycles mid-period -> tick delayed exactly 7 cycles; div_load plus sync same cycle -> new divisor in effect from sync.
REQ-037 rst_n low 1 cycle while pend_valid set -> all outputs 0, div_act back to DEFAULT_DIV, pending value lost.

Source files
------------

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and helpers for the clock divider bank
//
// Purpose: default bank geometry and the channel-index width function used to
//          size the div_ch port.
// Ports:   none (package).
package clk_div_pkg;

   localparam int DEF_NUM_CH      = 4;
   localparam int DEF_CNT_W       = 26;
   localparam int DEF_DEFAULT_DIV = 20_000_000;

   // Channel index width; kept at least 1 bit so a single-channel bank still has a port.
   function automatic int ch_idx_w(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/clk_div_ch.sv
// rtl/clk_div_ch.sv - single divider channel with glitch-free divisor update
//
// Purpose: counts up to div_act-1, emits a registered one-cycle tick on wrap and
//          toggles div_clk on every tick. New divisors are staged in div_pend
//          while running and taken on the next wrap or sync.
// Ports:   clk, rst_n    - clock, synchronous active-low reset
//          en            - run enable (hold when low)
//          load/load_val - validated divisor write for this channel
//          sync          - realign: clear count, force div_clk low
//          tick, div_clk - registered outputs
module clk_div_ch
   import clk_div_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int DEFAULT_DIV = DEF_DEFAULT_DIV
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             sync,
   output logic             tick,
   output logic             div_clk
);

   localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] div_act, act_nxt;
   logic [CNT_W-1:0] div_pend, pend_nxt;
   logic             pend_valid, pv_nxt;
   logic             tick_nxt, dclk_nxt;

   always_comb begin
      cnt_nxt  = cnt;
      act_nxt  = div_act;
      pend_nxt = div_pend;
      pv_nxt   = pend_valid;
      tick_nxt = 1'b0;
      dclk_nxt = div_clk;

      // Load first: a stopped channel takes the divisor at once, a running one stages it.
      if (load) begin
         if (en) begin
            pend_nxt = load_val;
            pv_nxt   = 1'b1;
         end else begin
            act_nxt = load_val;
            cnt_nxt = '0;
            pv_nxt  = 1'b0;
         end
      end

      // A load landing on the wrap cycle is promoted by that same wrap.
      if (en) begin
         if (cnt == div_act - ONE) begin
            cnt_nxt  = '0;
            tick_nxt = 1'b1;
            dclk_nxt = ~div_clk;
            if (pv_nxt) begin
               act_nxt = pend_nxt;
               pv_nxt  = 1'b0;
            end
         end else begin
            cnt_nxt = cnt + ONE;
         end
      end

      // Sync overrides counting and sees the divisor staged above.
      if (sync) begin
         cnt_nxt  = '0;
         dclk_nxt = 1'b0;
         tick_nxt = 1'b0;
         if (pv_nxt) begin
            act_nxt = pend_nxt;
            pv_nxt  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt        <= '0;
         div_act    <= RST_DIV;
         div_pend   <= RST_DIV;
         pend_valid <= 1'b0;
         tick       <= 1'b0;
         div_clk    <= 1'b0;
      end else begin
         cnt        <= cnt_nxt;
         div_act    <= act_nxt;
         div_pend   <= pend_nxt;
         pend_valid <= pv_nxt;
         tick       <= tick_nxt;
         div_clk    <= dclk_nxt;
      end
   end

endmodule

// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - bank of independent programmable clock dividers
//
// Purpose: NUM_CH divider channels sharing one load port and one sync strobe.
//          Invalid loads (zero divisor or out-of-range channel) are dropped and
//          flagged on load_err one cycle later.
// Ports:   clk, rst_n              - clock, synchronous active-low reset
//          en[NUM_CH]              - per-channel run enable
//          div_load/div_ch/div_val - divisor write strobe, target, value
//          sync                    - realign all channels
//          tick[NUM_CH]            - one-cycle pulse at terminal count
//          div_clk[NUM_CH]         - square-wave data outputs
//          load_err                - rejected-load pulse
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter int NUM_CH      = DEF_NUM_CH,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int DEFAULT_DIV = DEF_DEFAULT_DIV
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_CH-1:0]             en,
   input  logic                          div_load,
   input  logic [ch_idx_w(NUM_CH)-1:0]   div_ch,
   input  logic [CNT_W-1:0]              div_val,
   input  logic                          sync,
   output logic [NUM_CH-1:0]             tick,
   output logic [NUM_CH-1:0]             div_clk,
   output logic                          load_err
);

   logic div_ok;
   logic load_ok;

   assign div_ok  = (div_val != '0) && (int'(div_ch) < NUM_CH);
   assign load_ok = div_load && div_ok;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clk_div_ch #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .en       (en[i]),
         .load     (load_ok && (int'(div_ch) == i)),
         .load_val (div_val),
         .sync     (sync),
         .tick     (tick[i]),
         .div_clk  (div_clk[i])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         load_err <= 1'b0;
      end else begin
         load_err <= div_load && !div_ok;
      end
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb/tb_clk_div_bank.sv - scoreboard testbench for clk_div_bank
module tb_clk_div_bank;

   localparam int NUM_CH      = 3;
   localparam int CNT_W       = 8;
   localparam int DEFAULT_DIV = 5;
   localparam int CH_W        = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NUM_CH-1:0] en;
   logic              div_load;
   logic [CH_W-1:0]   div_ch;
   logic [CNT_W-1:0]  div_val;
   logic              sync;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] div_clk;
   logic              load_err;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   // ch == NUM_CH denotes a load_err pulse
   typedef struct {
      int   ch;
      int   cyc;
      logic dclk;
   } ev_t;

   ev_t exp_q[$];

   clk_div_bank #(
      .NUM_CH      (NUM_CH),
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .div_load (div_load),
      .div_ch   (div_ch),
      .div_val  (div_val),
      .sync     (sync),
      .tick     (tick),
      .div_clk  (div_clk),
      .load_err (load_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
      end
   endtask

   task automatic exp_ticks(input int ch, input int first, input int period, input int n,
                            input logic dclk_first);
      logic d;
      d = dclk_first;
      for (int k = 0; k < n; k++) begin
         exp_q.push_back('{ch, first + k * period, d});
         d = ~d;
      end
   endtask

   task automatic exp_err(input int c);
      exp_q.push_back('{NUM_CH, c, 1'b0});
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Monitor: every observed pulse is matched to the oldest expectation for its channel.
   always @(negedge clk) begin
      for (int i = 0; i <= NUM_CH; i++) begin
         logic hit;
         int   idx;
         if (i == NUM_CH) hit = load_err;
         else             hit = tick[i];
         if (hit === 1'b1) begin
            idx = -1;
            for (int k = 0; k < exp_q.size(); k++)
               if (idx < 0 && exp_q[k].ch == i) idx = k;
            if (idx < 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pulse ch%0d: got pulse at cycle %0d expected none", i, cyc);
            end else begin
               check($sformatf("pulse_cycle ch%0d", i), cyc, exp_q[idx].cyc);
               if (i < NUM_CH)
                  check($sformatf("div_clk_at_tick ch%0d cyc%0d", i, cyc),
                        32'(div_clk[i]), 32'(exp_q[idx].dclk));
               exp_q.delete(idx);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; en = '0; div_load = 1'b0; div_ch = '0; div_val = '0; sync = 1'b0;

      wait_cyc(3);
      check("reset_tick", 32'(tick), 0);
      check("reset_div_clk", 32'(div_clk), 0);
      check("reset_load_err", 32'(load_err), 0);

      // Default divisor 5 on ch0; first tick 5 cycles after release
      exp_ticks(0, 8, 5, 5, 1'b1);
      rst_n = 1'b1; en = 3'b001;

      // Load 3 at cnt==1: the period in flight completes first
      wait_cyc(24);
      exp_ticks(0, 31, 3, 7, 1'b0);
      div_load = 1'b1; div_ch = 2'd0; div_val = 8'd3;
      wait_cyc(25); div_load = 1'b0;

      // Zero divisor, then out-of-range channel
      wait_cyc(40);
      exp_err(41); exp_err(42);
      div_load = 1'b1; div_ch = 2'd0; div_val = 8'd0;
      wait_cyc(41); div_ch = 2'd3; div_val = 8'd7;
      wait_cyc(42); div_load = 1'b0;
      wait_cyc(49); en = '0;

      // ch0 div 4, ch1 div 6 loaded while stopped, then run and sync
      wait_cyc(50); div_load = 1'b1; div_ch = 2'd0; div_val = 8'd4;
      wait_cyc(51); div_ch = 2'd1; div_val = 8'd6;
      wait_cyc(52); div_load = 1'b0; en = 3'b011;
      exp_ticks(0, 56, 4, 3, 1'b1); exp_ticks(1, 58, 6, 2, 1'b1);
      exp_ticks(0, 71, 4, 3, 1'b1); exp_ticks(1, 73, 6, 2, 1'b1);
      wait_cyc(66); sync = 1'b1;
      wait_cyc(67); sync = 1'b0;
      check("sync_div_clk", 32'(div_clk), 0);
      check("sync_tick", 32'(tick), 0);
      wait_cyc(79); en = '0;

      // ch2: enable gap of 7 cycles mid-period
      wait_cyc(80); en = 3'b100;
      exp_ticks(2, 85, 5, 2, 1'b1); exp_ticks(2, 102, 5, 2, 1'b1);
      wait_cyc(92); en = '0;
      wait_cyc(99); en = 3'b100;

      // Load plus sync in the same cycle
      wait_cyc(108);
      exp_ticks(2, 111, 2, 3, 1'b1);
      div_load = 1'b1; div_ch = 2'd2; div_val = 8'd2; sync = 1'b1;
      wait_cyc(109); div_load = 1'b0; sync = 1'b0;
      check("load_sync_div_clk", 32'(div_clk), 0);

      // Stage 7 on ch2, then reset before the wrap that would take it
      wait_cyc(115); div_load = 1'b1; div_ch = 2'd2; div_val = 8'd7;
      wait_cyc(116); div_load = 1'b0; rst_n = 1'b0;
      wait_cyc(117); rst_n = 1'b1;
      check("rst2_tick", 32'(tick), 0);
      check("rst2_div_clk", 32'(div_clk), 0);
      check("rst2_load_err", 32'(load_err), 0);
      exp_ticks(2, 122, 5, 2, 1'b1);
      wait_cyc(127); en = '0;

      // Divisor 1 on ch1: tick every cycle
      wait_cyc(128); div_load = 1'b1; div_ch = 2'd1; div_val = 8'd1;
      wait_cyc(129); div_load = 1'b0; en = 3'b010;
      exp_ticks(1, 130, 1, 4, 1'b1);
      wait_cyc(133); en = '0;

      wait_cyc(140);
      foreach (exp_q[k]) begin
         checks++;
         errors++;
         $display("FAIL missing_pulse ch%0d: got none expected pulse at cycle %0d",
                  exp_q[k].ch, exp_q[k].cyc);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
